// File: rtl/dcache_weights_fetch.sv
// ----------------------------------------------------------------------------
// dcache_weights_fetch
//
// Read initiator for the weight cache. On a start pulse it walks a contiguous
// block of 64-bit words beginning at base_addr, issues one read per word and
// captures the returned data into a small first-word-fall-through FIFO that
// feeds the PE array over a valid/ready stream.
//
// Optional feature (macro WFETCH_TIMEOUT_EN):
//   defined   - a per-request watchdog counts read cycles without valid; on
//               reaching TIMEOUT_CYCLES it sets the sticky error flag and
//               ends the block early through DONE.
//   undefined - no watchdog; error is tied to 0.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous reset, active-high
//   start      in   1      launch pulse, honoured only in IDLE
//   base_addr  in   WIDTH  byte address of first word (8-byte aligned)
//   num_words  in   CNT_W  number of 64-bit words to fetch
//   address    out  WIDTH  cache request address
//   read       out  1      cache read request
//   data_in    in   64     cache read data
//   valid      in   1      cache data valid (qualified by read)
//   out_data   out  64     FIFO head word
//   out_valid  out  1      FIFO not empty
//   out_ready  in   1      consumer accepts head word
//   busy       out  1      high in REQ and DONE
//   done       out  1      one-cycle end-of-block pulse
//   error      out  1      sticky timeout flag, cleared by the next start
// ----------------------------------------------------------------------------
module dcache_weights_fetch #(
    parameter int WIDTH          = 32,
    parameter int CNT_W          = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0] num_words,
    output logic [WIDTH-1:0] address,
    output logic             read,
    input  logic [63:0]      data_in,
    input  logic             valid,
    output logic [63:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic fifo_full;
    logic push;
    logic pop;
    logic timeout_hit;

    assign fifo_full = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    // Capture only happens while the request is actually being driven.
    assign push      = read && valid;
    assign out_data  = mem_q[rd_ptr_q];
    assign address   = addr_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d = S_REQ;
                        addr_d  = base_addr;
                        rem_d   = num_words;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (push) begin
                    // Natural modulo-2^WIDTH wrap of the address.
                    addr_d = addr_q + WIDTH'(8);
                    rem_d  = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        // A same-cycle pop frees an entry, so a full FIFO with the
        // consumer accepting still allows a read this cycle.
        read = (state_q == S_REQ) && (!fifo_full || pop);
    end

    // ------------------------------------------------------------------
    // Output FIFO: control
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Output FIFO: storage (data path, no reset needed).
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef WFETCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            error_q, error_d;

    // Counts only stalled request cycles; a full FIFO (read=0) neither
    // advances nor clears it.
    always_comb begin
        wdog_d      = wdog_q;
        error_d     = error_q;
        timeout_hit = 1'b0;
        if ((state_q == S_IDLE) && start) begin
            wdog_d  = '0;
            error_d = 1'b0;
        end else if (push) begin
            wdog_d = '0;
        end else if (read) begin
            if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
                error_d     = 1'b1;
                wdog_d      = '0;
            end else begin
                wdog_d = wdog_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

endmodule
